cpu_spi_rx_packer: RTL and testbench

- Receive front end between the CPU SPI pins and the SRAM FIFO_I write port; feeds the SRAM controller's slave-side write interface.
- Oversamples cpu_sclk/cpu_mosi/cpu_ss_n in the clk domain and deserializes SPI mode 0, MSB first.
- Packs byte pairs into 16-bit words, buffers them in a small internal FIFO, and writes them to SRAM under the grant/full handshake.
- Reports per-frame byte count and overflow status.

---
 rtl/cpu_spi_rx_packer.sv | 199 +++++++++++++++++++
 tb/tb_cpu_spi_rx_packer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_spi_rx_packer.sv
// SPI mode-0 receive front end: oversampled deserializer, byte-pair packer,
// small word FIFO and SRAM FIFO_I write handshake with per-frame status.
module cpu_spi_rx_packer #(
   parameter int SYNC_STAGES = 2,
   parameter int BUF_DEPTH   = 4,
   parameter int LEN_W       = 11
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             cpu_sclk,
   input  logic             cpu_mosi,
   input  logic             cpu_ss_n,
   input  logic             sram_hint,
   input  logic             sram_full,
   output logic             sram_write,
   output logic [15:0]      sram_data,
   output logic             frame_done,
   output logic [LEN_W-1:0] frame_len,
   output logic             frame_odd,
   output logic             overflow,
   output logic             busy
);

   localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_FLUSH} state_t;

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
   logic sclk_rise, ss_fall, ss_rise, mosi_s;

   logic [6:0]       shift_q;
   logic [2:0]       bit_cnt_q;
   logic [7:0]       pend_q;
   logic             pend_vld_q;
   logic [LEN_W-1:0] byte_cnt_q;
   logic             odd_q;

   logic [7:0]  new_byte;
   logic        push, frame_start, frame_end, flush_pad, sample, byte_done;
   logic [15:0] push_data;

   logic [15:0] mem [BUF_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   fifo_cnt;
   logic fifo_full, fifo_empty, pop, do_push, drop;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sclk_sync <= '0;
         mosi_sync <= '0;
         ss_sync   <= '1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], cpu_sclk};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], cpu_mosi};
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], cpu_ss_n};
      end
   end

   assign sclk_rise = sclk_sync[SYNC_STAGES-2] & ~sclk_sync[SYNC_STAGES-1];
   assign ss_fall   = ~ss_sync[SYNC_STAGES-2] & ss_sync[SYNC_STAGES-1];
   assign ss_rise   = ss_sync[SYNC_STAGES-2] & ~ss_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign new_byte  = {shift_q, mosi_s};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      push        = 1'b0;
      push_data   = '0;
      frame_start = 1'b0;
      frame_end   = 1'b0;
      flush_pad   = 1'b0;
      sample      = 1'b0;
      byte_done   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (ss_fall) begin
               state_d     = ST_ACTIVE;
               frame_start = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (ss_rise) begin
               // any partial byte is simply abandoned with bit_cnt
               state_d = ST_FLUSH;
               if (pend_vld_q) begin
                  push      = 1'b1;
                  push_data = {pend_q, 8'h00};
                  flush_pad = 1'b1;
               end
            end else if (sclk_rise) begin
               sample = 1'b1;
               if (bit_cnt_q == 3'd7) begin
                  byte_done = 1'b1;
                  if (pend_vld_q) begin
                     push      = 1'b1;
                     push_data = {pend_q, new_byte};
                  end
               end
            end
         end
         ST_FLUSH: begin
            if (fifo_empty && !sram_write) begin
               state_d   = ST_IDLE;
               frame_end = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         byte_cnt_q <= '0;
         odd_q      <= 1'b0;
      end else if (frame_start) begin
         bit_cnt_q  <= '0;
         pend_vld_q <= 1'b0;
         byte_cnt_q <= '0;
         odd_q      <= 1'b0;
      end else if (flush_pad) begin
         pend_vld_q <= 1'b0;
         odd_q      <= 1'b1;
      end else if (sample) begin
         shift_q   <= new_byte[6:0];
         bit_cnt_q <= bit_cnt_q + 3'd1;
         if (byte_done) begin
            if (byte_cnt_q != '1) byte_cnt_q <= byte_cnt_q + LEN_W'(1);
            if (pend_vld_q) begin
               pend_vld_q <= 1'b0;
            end else begin
               pend_q     <= new_byte;
               pend_vld_q <= 1'b1;
            end
         end
      end
   end

   assign fifo_empty = (fifo_cnt == '0);
   assign fifo_full  = (fifo_cnt == (AW+1)'(BUF_DEPTH));
   assign pop        = ~fifo_empty & sram_hint & ~sram_full;
   assign do_push    = push & (~fifo_full | pop);
   assign drop       = push & fifo_full & ~pop;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // the FIFO head leaves on the same edge that raises the registered strobe
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_cnt   <= '0;
         sram_write <= 1'b0;
         sram_data  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         unique case ({do_push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
            2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
         sram_write <= pop;
         if (pop) sram_data <= mem[rd_ptr];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow   <= 1'b0;
         frame_done <= 1'b0;
         frame_len  <= '0;
         frame_odd  <= 1'b0;
      end else begin
         if (frame_start)  overflow <= 1'b0;
         else if (drop)    overflow <= 1'b1;
         frame_done <= frame_end;
         if (frame_end) begin
            frame_len <= byte_cnt_q;
            frame_odd <= odd_q;
         end
      end
   end

   assign busy = (state_q != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_cpu_spi_rx_packer.sv
// Scoreboard bench for cpu_spi_rx_packer: expected SRAM words and frame
// status records are queued by the stimulus and consumed by a monitor.
module tb_cpu_spi_rx_packer;

   localparam int LEN_W = 11;

   typedef struct packed {
      logic [LEN_W-1:0] len;
      logic             odd;
      logic             ovf;
   } frm_t;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             cpu_sclk, cpu_mosi, cpu_ss_n;
   logic             sram_hint, sram_full;
   logic             sram_write;
   logic [15:0]      sram_data;
   logic             frame_done;
   logic [LEN_W-1:0] frame_len;
   logic             frame_odd;
   logic             overflow;
   logic             busy;

   int checks = 0;
   int errors = 0;
   int writes_seen = 0;
   int frames_seen = 0;

   logic [15:0] exp_w[$];
   frm_t        exp_f[$];

   cpu_spi_rx_packer #(.SYNC_STAGES(2), .BUF_DEPTH(4), .LEN_W(LEN_W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cpu_sclk   (cpu_sclk),
      .cpu_mosi   (cpu_mosi),
      .cpu_ss_n   (cpu_ss_n),
      .sram_hint  (sram_hint),
      .sram_full  (sram_full),
      .sram_write (sram_write),
      .sram_data  (sram_data),
      .frame_done (frame_done),
      .frame_len  (frame_len),
      .frame_odd  (frame_odd),
      .overflow   (overflow),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (reset_n) begin
         if (sram_write) begin
            writes_seen++;
            checks++;
            if (exp_w.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write got %h required no write", sram_data);
            end else begin
               logic [15:0] e;
               e = exp_w.pop_front();
               if (sram_data !== e) begin
                  errors++;
                  $display("FAIL sram_data got %h required %h", sram_data, e);
               end
            end
         end
         if (frame_done) begin
            frames_seen++;
            checks++;
            if (exp_f.size() == 0) begin
               errors++;
               $display("FAIL unexpected_frame_done len %0d odd %0d ovf %0d",
                        frame_len, frame_odd, overflow);
            end else begin
               frm_t f;
               f = exp_f.pop_front();
               if ({frame_len, frame_odd, overflow} !== f) begin
                  errors++;
                  $display("FAIL frame_status got len %0d odd %0d ovf %0d required len %0d odd %0d ovf %0d",
                           frame_len, frame_odd, overflow, f.len, f.odd, f.ovf);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h required %h", name, got, exp);
      end
   endtask

   task automatic spi_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         cpu_mosi = b[i];
         #50 cpu_sclk = 1'b1;
         #50 cpu_sclk = 1'b0;
      end
   endtask

   task automatic frame_begin();
      cpu_ss_n = 1'b0;
      #100;
   endtask

   task automatic frame_end();
      #100 cpu_ss_n = 1'b1;
      #200;
   endtask

   task automatic wait_frames(input int n, input string name);
      int cyc;
      cyc = 0;
      while (frames_seen < n && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      chk({name, "_timeout"}, 32'(frames_seen >= n), 32'd1);
   endtask

   initial begin
      int w0, f0;
      reset_n   = 1'b0;
      cpu_sclk  = 1'b0;
      cpu_mosi  = 1'b0;
      cpu_ss_n  = 1'b1;
      sram_hint = 1'b1;
      sram_full = 1'b0;
      #23;
      chk("reset_outputs",
          {sram_write, sram_data, frame_done, frame_len, frame_odd, overflow, busy}, '0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      // two bytes -> one word
      exp_w.push_back(16'hA53C);
      exp_f.push_back('{len: 11'd2, odd: 1'b0, ovf: 1'b0});
      frame_begin();
      spi_byte(8'hA5);
      spi_byte(8'h3C);
      frame_end();
      wait_frames(1, "frame1");
      chk("busy_idle", 32'(busy), 32'd0);

      // odd byte count -> padded low byte
      exp_w.push_back(16'h1122);
      exp_w.push_back(16'h3300);
      exp_f.push_back('{len: 11'd3, odd: 1'b1, ovf: 1'b0});
      frame_begin();
      spi_byte(8'h11);
      spi_byte(8'h22);
      spi_byte(8'h33);
      frame_end();
      wait_frames(2, "frame2");

      // partial byte only -> no write, len 0
      exp_f.push_back('{len: 11'd0, odd: 1'b0, ovf: 1'b0});
      frame_begin();
      for (int i = 0; i < 5; i++) begin
         cpu_mosi = 1'b1;
         #50 cpu_sclk = 1'b1;
         #50 cpu_sclk = 1'b0;
      end
      frame_end();
      wait_frames(3, "frame3");

      // no grant for 12 bytes: 4 words kept, 2 dropped
      @(negedge clk);
      sram_hint = 1'b0;
      w0 = writes_seen;
      f0 = frames_seen;
      frame_begin();
      for (int i = 1; i <= 12; i++) spi_byte(8'(i));
      frame_end();
      repeat (10) @(negedge clk);
      chk("overflow_set", 32'(overflow), 32'd1);
      chk("busy_flush", 32'(busy), 32'd1);
      chk("no_write_without_hint", 32'(writes_seen - w0), 32'd0);
      chk("no_done_before_drain", 32'(frames_seen - f0), 32'd0);
      exp_w.push_back(16'h0102);
      exp_w.push_back(16'h0304);
      exp_w.push_back(16'h0506);
      exp_w.push_back(16'h0708);
      exp_f.push_back('{len: 11'd12, odd: 1'b0, ovf: 1'b1});
      @(negedge clk);
      sram_hint = 1'b1;
      wait_frames(4, "frame4");
      chk("drain_count", 32'(writes_seen - w0), 32'd4);

      // full blocks writes while hint is high
      @(negedge clk);
      sram_full = 1'b1;
      w0 = writes_seen;
      frame_begin();
      chk("overflow_cleared", 32'(overflow), 32'd0);
      spi_byte(8'h12);
      spi_byte(8'h34);
      spi_byte(8'h56);
      spi_byte(8'h78);
      frame_end();
      repeat (20) @(negedge clk);
      chk("no_write_when_full", 32'(writes_seen - w0), 32'd0);
      chk("busy_when_full", 32'(busy), 32'd1);
      exp_w.push_back(16'h1234);
      exp_w.push_back(16'h5678);
      exp_f.push_back('{len: 11'd4, odd: 1'b0, ovf: 1'b0});
      sram_full = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (sram_write) break;
      end
      chk("first_write_after_full", 32'(sram_write), 32'd1);
      @(negedge clk);
      chk("second_write_consecutive", 32'(sram_write), 32'd1);
      wait_frames(5, "frame5");

      // reset mid-frame
      frame_begin();
      spi_byte(8'h99);
      #30 reset_n = 1'b0;
      #1;
      chk("reset_midframe_outputs",
          {sram_write, sram_data, frame_done, frame_len, frame_odd, overflow, busy}, '0);
      cpu_ss_n = 1'b1;
      cpu_sclk = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("after_reset_quiet", {31'd0, busy}, 32'd0);
      exp_w.push_back(16'hBEEF);
      exp_f.push_back('{len: 11'd2, odd: 1'b0, ovf: 1'b0});
      frame_begin();
      spi_byte(8'hBE);
      spi_byte(8'hEF);
      frame_end();
      wait_frames(6, "frame6");

      repeat (10) @(negedge clk);
      chk("words_outstanding", 32'(exp_w.size()), 32'd0);
      chk("frames_outstanding", 32'(exp_f.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got running required finished");
      $fatal(1, "timeout");
   end

endmodule
